// File: rtl/opram_lvt.sv
// Multi-read, multi-write operand RAM: one storage bank per write port, a live-value
// table selecting the bank that holds each entry's newest value, and a valid table.
module opram_lvt #(
  parameter int DEPTH  = 32,
  parameter int WIDTH  = 2,
  parameter int NR     = 7,
  parameter int NW     = 2,
  parameter int BYPASS = 1
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  CEN,
  input  logic                  CLR,
  input  logic [NW-1:0]         WEN,
  input  logic [NW*$clog2(DEPTH)-1:0] AW_I,
  input  logic [NW*WIDTH-1:0]   DI,
  input  logic [NR*$clog2(DEPTH)-1:0] A,
  output logic [NR*WIDTH-1:0]   Q
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = (NW > 1) ? $clog2(NW) : 1;

  logic [NW-1:0]                         we;
  logic [NW-1:0][DEPTH-1:0][WIDTH-1:0]   bank_q, bank_d;
  logic [DEPTH-1:0][LW-1:0]              lvt_q, lvt_d;
  logic [DEPTH-1:0]                      valid_q, valid_d;
  logic [NR-1:0][AW-1:0]                 rd_addr;
  logic [NR-1:0][WIDTH-1:0]              rd_data;

  // Writes are dropped while reset is held so nothing leaks past the valid clear.
  assign we = WEN & {NW{CEN & RSTN}};

  // Ascending port order makes the highest-index writer own the LVT entry on a conflict.
  always_comb begin
    bank_d  = bank_q;
    lvt_d   = lvt_q;
    valid_d = CLR ? '0 : valid_q;
    for (int w = 0; w < NW; w++) begin
      if (we[w]) begin
        bank_d[w][AW_I[w*AW +: AW]] = DI[w*WIDTH +: WIDTH];
        lvt_d[AW_I[w*AW +: AW]]     = LW'(w);
        valid_d[AW_I[w*AW +: AW]]   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      lvt_q   <= '0;
      valid_q <= '0;
    end else begin
      lvt_q   <= lvt_d;
      valid_q <= valid_d;
    end
  end

  // Bank contents are don't-care until written; the valid table masks them.
  always_ff @(posedge CLK) begin
    bank_q <= bank_d;
  end

  always_comb begin
    rd_addr = '0;
    rd_data = '0;
    Q       = '0;
    for (int r = 0; r < NR; r++) begin
      rd_addr[r] = A[r*AW +: AW];
      if (valid_q[rd_addr[r]]) begin
        for (int w = 0; w < NW; w++) begin
          if (lvt_q[rd_addr[r]] == LW'(w)) begin
            rd_data[r] = bank_q[w][rd_addr[r]];
          end
        end
      end
      if (BYPASS != 0) begin
        for (int w = 0; w < NW; w++) begin
          if (we[w] && (AW_I[w*AW +: AW] == rd_addr[r])) begin
            rd_data[r] = DI[w*WIDTH +: WIDTH];
          end
        end
      end
      Q[r*WIDTH +: WIDTH] = rd_data[r];
    end
  end

endmodule

// File: tb/tb_opram_lvt.sv
// Scoreboarded bench for opram_lvt: bypass and non-bypass instances share stimulus and
// are compared against an entry-level reference model (live value + valid per address).
module tb_opram_lvt;

  localparam int DEPTH = 32;
  localparam int WIDTH = 2;
  localparam int NR    = 7;
  localparam int NW    = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                cen = 1'b0;
  logic                clr = 1'b0;
  logic [NW-1:0]       wen = '0;
  logic [NW*AW-1:0]    aw_i = '0;
  logic [NW*WIDTH-1:0] di = '0;
  logic [NR*AW-1:0]    a = '0;
  logic [NR*WIDTH-1:0] q_b, q_nb;

  always #5 clk = ~clk;

  opram_lvt #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NR(NR), .NW(NW), .BYPASS(1)) dut_b (
    .CLK(clk), .RSTN(rstn), .CEN(cen), .CLR(clr), .WEN(wen),
    .AW_I(aw_i), .DI(di), .A(a), .Q(q_b)
  );

  opram_lvt #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NR(NR), .NW(NW), .BYPASS(0)) dut_nb (
    .CLK(clk), .RSTN(rstn), .CEN(cen), .CLR(clr), .WEN(wen),
    .AW_I(aw_i), .DI(di), .A(a), .Q(q_nb)
  );

  // Reference model: the value last written to each address, and whether it is valid.
  logic [WIDTH-1:0] m_val [DEPTH];
  bit               m_valid [DEPTH];

  typedef struct {
    logic [NR*WIDTH-1:0] exp_b;
    logic [NR*WIDTH-1:0] exp_nb;
  } exp_t;

  exp_t  sb[$];
  string tag_q[$];
  event  chk_ev;
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic logic [WIDTH-1:0] ref_read(int addr, bit byp);
    logic [WIDTH-1:0] v;
    if (!rstn) return '0;
    v = m_valid[addr] ? m_val[addr] : '0;
    if (byp) begin
      for (int w = 0; w < NW; w++) begin
        if (cen && wen[w] && int'(aw_i[w*AW +: AW]) == addr) v = di[w*WIDTH +: WIDTH];
      end
    end
    return v;
  endfunction

  task automatic push_expect(input string tag);
    exp_t e;
    for (int r = 0; r < NR; r++) begin
      e.exp_b[r*WIDTH +: WIDTH]  = ref_read(int'(a[r*AW +: AW]), 1'b1);
      e.exp_nb[r*WIDTH +: WIDTH] = ref_read(int'(a[r*AW +: AW]), 1'b0);
    end
    sb.push_back(e);
    tag_q.push_back(tag);
    -> chk_ev;
  endtask

  // Queue the expected read results for the current inputs, then apply the write at the edge.
  task automatic step(input string tag);
    push_expect(tag);
    @(posedge clk);
    if (rstn) begin
      if (clr) for (int d = 0; d < DEPTH; d++) m_valid[d] = 1'b0;
      for (int w = 0; w < NW; w++) begin
        if (cen && wen[w]) begin
          m_val[int'(aw_i[w*AW +: AW])]   = di[w*WIDTH +: WIDTH];
          m_valid[int'(aw_i[w*AW +: AW])] = 1'b1;
        end
      end
    end
  endtask

  task automatic idle();
    cen = 1'b1; clr = 1'b0; wen = '0;
  endtask

  task automatic set_w(input int w, input int addr, input int data);
    wen[w] = 1'b1;
    aw_i[w*AW +: AW]    = AW'(addr);
    di[w*WIDTH +: WIDTH] = WIDTH'(data);
  endtask

  task automatic set_a(input int r, input int addr);
    a[r*AW +: AW] = AW'(addr);
  endtask

  task automatic set_all_a(input int addr);
    for (int r = 0; r < NR; r++) set_a(r, addr);
  endtask

  // Monitor: drains the scoreboard shortly after each expectation is posted.
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(chk_ev);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        t = tag_q.pop_front();
        n_checks++;
        if (q_b !== e.exp_b) begin
          n_fail++;
          $display("FAIL %s bypass: Q=%h expected %h", t, q_b, e.exp_b);
        end
        n_checks++;
        if (q_nb !== e.exp_nb) begin
          n_fail++;
          $display("FAIL %s no_bypass: Q=%h expected %h", t, q_nb, e.exp_nb);
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < DEPTH; d++) begin
      m_val[d] = '0;
      m_valid[d] = 1'b0;
    end

    // Reset held for three cycles with writes offered; all of them must be ignored.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cen = 1'b1; wen = '1;
      set_w(0, i, 3); set_w(1, i + 8, 2);
      for (int r = 0; r < NR; r++) set_a(r, (i * NR + r) % DEPTH);
      step("in_reset");
    end
    @(negedge clk);
    rstn = 1'b1;
    idle();
    for (int base = 0; base < DEPTH; base += NR) begin
      for (int r = 0; r < NR; r++) set_a(r, (base + r) % DEPTH);
      step("sweep");
      @(negedge clk);
    end

    // Single write and readback.
    idle(); set_all_a(6); set_w(0, 5, 3);
    step("wr5");
    @(negedge clk); idle(); set_all_a(6); set_a(3, 5);
    step("rd5");

    // Same-address conflict, then the LVT follows the latest writer.
    @(negedge clk); idle(); set_all_a(9); set_w(0, 9, 1); set_w(1, 9, 2);
    step("conf_wr");
    @(negedge clk); idle();
    step("conf_rd");
    @(negedge clk); idle(); set_w(0, 9, 3);
    step("conf_wr0");
    @(negedge clk); idle();
    step("conf_rd0");

    // Same-cycle read of an address being written.
    @(negedge clk); idle(); set_all_a(7); set_a(0, 4); set_w(0, 4, 2);
    step("byp");
    @(negedge clk); idle();
    step("byp_rd");

    // Clear combined with a write.
    @(negedge clk); idle(); set_w(0, 1, 3); set_w(1, 2, 2);
    step("clr_prep1");
    @(negedge clk); idle(); set_w(0, 3, 1);
    step("clr_prep2");
    @(negedge clk); idle(); set_all_a(0); set_a(0, 1); set_a(1, 2); set_a(2, 3);
    clr = 1'b1; set_w(1, 2, 1);
    step("clr_wr");
    @(negedge clk); idle();
    step("clr_rd");

    // CEN low gates every write enable.
    @(negedge clk); idle(); cen = 1'b0; wen = '1;
    set_w(0, 1, 2); set_w(1, 2, 3); set_a(3, 9); set_a(4, 4);
    step("cen_off");
    @(negedge clk); idle();
    step("cen_rd");

    // Randomized traffic; a narrow address window forces conflicts and bypass hits.
    for (int i = 0; i < 400; i++) begin
      bit narrow;
      @(negedge clk);
      narrow = ($urandom_range(0, 1) == 1);
      cen = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 31) == 0);
      wen = NW'($urandom_range(0, (1 << NW) - 1));
      for (int w = 0; w < NW; w++) begin
        aw_i[w*AW +: AW]     = AW'(narrow ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1));
        di[w*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      end
      for (int r = 0; r < NR; r++)
        set_a(r, narrow ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1));
      step("rand");
    end

    // Populate, then assert reset between edges; Q must fall before the next edge.
    @(negedge clk); idle(); set_w(0, 10, 3); set_w(1, 11, 2);
    step("pre_rst_wr");
    @(negedge clk); idle(); set_all_a(10); set_a(1, 11);
    push_expect("pre_rst");
    #2;
    rstn = 1'b0;
    for (int d = 0; d < DEPTH; d++) m_valid[d] = 1'b0;
    push_expect("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    step("post_rst");

    @(negedge clk);
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/opram_lvt.md
# opram_lvt

Parametrised multi-read, multi-write operand RAM for the issue and rename stages. It generalises the fixed 32x2, 7-read/1-write operand RAM to configurable depth, width, read-port count and write-port count. Multiple write ports are supported through per-write-port storage banks plus a live-value table (LVT). The block adds reset-to-zero semantics through a valid table, a single-cycle clear, deterministic write-conflict priority, and optional write-to-read bypass.

## Interface
Parameters:
- DEPTH, 32, number of entries (power of two, 2..64)
- WIDTH, 2, data bits per entry
- NR, 7, number of read ports (1..8)
- NW, 2, number of write ports (1..4)
- BYPASS, 1, 1 = read of an address being written this cycle returns the new data; 0 = returns the stored value

Ports (AW = clog2(DEPTH)):
- CLK  in  1  clock; all state updates on rising edge
- RSTN  in  1  asynchronous active-low reset
- CEN  in  1  active-high global write enable; when 0, all WEN bits are ignored
- CLR  in  1  synchronous clear: invalidates every entry in one cycle
- WEN  in  NW  per-write-port enable
- AW_I  in  NW*AW  write addresses; port w = bits [w*AW +: AW]
- DI  in  NW*WIDTH  write data; port w = bits [w*WIDTH +: WIDTH]
- A  in  NR*AW  read addresses; port r = bits [r*AW +: AW]
- Q  out  NR*WIDTH  read data; port r = bits [r*WIDTH +: WIDTH]; combinational from A and state

## Operation
- Storage: NW banks, each DEPTH x WIDTH. Bank w is written only by write port w. Banks are not reset.
- LVT: DEPTH entries of max(1, clog2(NW)) bits, recording which bank holds the live value. Valid table: DEPTH bits.
- Effective write: port w writes when CEN & WEN[w]. At the edge:
  - bank[w][AW_I[w]] <= DI[w]
  - lvt[AW_I[w]] <= w
  - valid[AW_I[w]] <= 1
- Write conflict: if two or more effective writes target the same address, the highest-index port wins the LVT entry. Losing banks still store their data, but that data is never visible.
- Read: Q[r] = valid[A[r]] ? bank[lvt[A[r]]][A[r]] : 0.
- Bypass (BYPASS=1): if any effective write this cycle targets A[r], Q[r] = DI of the highest-index such port, regardless of valid state. CLR does not suppress bypass.
- CLR: valid <= all-zero at the edge. If CLR and an effective write occur in the same cycle, the written addresses end valid with the new data; all others end invalid.
- Reset (RSTN low): valid and LVT clear to 0 immediately. All Q read 0 while in reset and afterwards until an address is written. Writes are ignored while RSTN is low.
- NW=1: the LVT degenerates to constant 0; behaviour equals a single-bank RAM with a valid table.

## Timing
- Write latency: 1 cycle. Data written at edge N is readable, without bypass, combinationally after edge N.
- Read latency: 0 cycles (asynchronous read); no read enable.
- With BYPASS=0, a read in the same cycle as a write to the same address returns the pre-edge value.
- Reset asserted mid-cycle clears valid and LVT without waiting for CLK. Deassertion is expected synchronous to CLK externally; the first accepted write is at the first rising edge with RSTN high.
- Output reset value: Q = 0 on all ports.
- No internal pipelining; no backpressure; every cycle accepts NW writes and serves NR reads.

## Test plan
- Reset then read all: RSTN low 3 cycles, release, sweep all A over 0..31 on 7 ports -> every Q = 2'b00.
- Single write/readback (defaults): WEN=01, AW_I[0]=5, DI[0]=2'b11; next cycle A[3]=5 -> Q[3]=2'b11. Other ports reading 6 -> 0.
- Conflict: same cycle WEN=11, both AW_I=9, DI[0]=01, DI[1]=10 -> next cycle Q at address 9 = 10. Then port 0 writes 9 with 11 -> reads 11 (LVT follows the latest writer).
- Bypass: BYPASS=1, write address 4 = 10 while A[0]=4 -> Q[0]=10 in the same cycle. With BYPASS=0, Q[0] = the prior value (0 after reset).
- CLR with write: addresses 1, 2, 3 valid; assert CLR with port 1 writing address 2 = 01 -> next cycle address 1 = 0, address 2 = 01, address 3 = 0.
- CEN gating and async reset mid-stream: CEN=0 with WEN=11 -> no entry changes. Assert RSTN low between edges -> Q drops to 0 before the next CLK edge.
